// File: rtl/servo_pwm_generator.sv
// Hobby-servo PWM generator: fixed frame period, clamped pulse width, one-entry
// pending register so a new width only takes effect at a frame boundary.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | output low, counters parked at 0, waiting for ENABLE
// ST_HIGH | pulse phase, PWM_OUT high until us counter reaches ACTIVE_US
// ST_LOW  | remainder of frame, output low until the frame wraps
module servo_pwm_generator #(
  parameter int CLK_PER_US = 50,
  parameter int FRAME_US   = 20000,
  parameter int MIN_US     = 800,
  parameter int MAX_US     = 2200,
  parameter int DEFAULT_US = 1500
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic [11:0] WIDTH_US,
  input  logic        WIDTH_VALID,
  output logic        WIDTH_READY,
  output logic        PWM_OUT,
  output logic        FRAME_START,
  output logic [11:0] ACTIVE_US
);

  localparam int PSC_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int US_W  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  // One extra bit so us_cnt + 1 never wraps in the pulse-end compare.
  localparam int CMP_W = ((US_W > 12) ? US_W : 12) + 1;

  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLK_PER_US - 1);
  localparam logic [US_W-1:0]  US_LAST  = US_W'(FRAME_US - 1);
  localparam logic [11:0]      MIN_W    = 12'(MIN_US);
  localparam logic [11:0]      MAX_W    = 12'(MAX_US);
  localparam logic [11:0]      DEF_W    = 12'(DEFAULT_US);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

  state_t            state;
  logic [PSC_W-1:0]  psc;
  logic [US_W-1:0]   us_cnt;
  logic              pend_full;
  logic [11:0]       pend_us;
  logic [11:0]       width_clamped;
  logic              us_tick;
  logic              frame_end;
  logic              pulse_end;
  logic              frame_go;

  always_comb begin
    width_clamped = WIDTH_US;
    if (WIDTH_US < MIN_W)
      width_clamped = MIN_W;
    else if (WIDTH_US > MAX_W)
      width_clamped = MAX_W;
  end

  always_comb begin
    us_tick   = (state != ST_IDLE) && (psc == PSC_LAST);
    frame_end = us_tick && (us_cnt == US_LAST);
    pulse_end = us_tick && ((CMP_W'(us_cnt) + CMP_W'(1)) == CMP_W'(ACTIVE_US));
    frame_go  = ENABLE && ((state == ST_IDLE) || frame_end);
  end

  assign WIDTH_READY = ~pend_full;

  // ACTIVE_US must stay below FRAME_US so the pulse always ends inside the frame.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      psc         <= '0;
      us_cnt      <= '0;
      PWM_OUT     <= 1'b0;
      FRAME_START <= 1'b0;
      ACTIVE_US   <= DEF_W;
      pend_full   <= 1'b0;
      pend_us     <= DEF_W;
    end else begin
      FRAME_START <= frame_go;

      if (state == ST_IDLE || us_tick)
        psc <= '0;
      else
        psc <= psc + PSC_W'(1);

      if (state == ST_IDLE || frame_end)
        us_cnt <= '0;
      else if (us_tick)
        us_cnt <= us_cnt + US_W'(1);

      // A frame start drains the pending slot; the edge it does so is never an accept edge.
      if (frame_go && pend_full) begin
        ACTIVE_US <= pend_us;
        pend_full <= 1'b0;
      end else if (WIDTH_VALID && !pend_full) begin
        pend_us   <= width_clamped;
        pend_full <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (ENABLE) begin
            state   <= ST_HIGH;
            PWM_OUT <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (pulse_end) begin
            state   <= ST_LOW;
            PWM_OUT <= 1'b0;
          end
        end
        ST_LOW: begin
          if (frame_end) begin
            if (ENABLE) begin
              state   <= ST_HIGH;
              PWM_OUT <= 1'b1;
            end else begin
              state   <= ST_IDLE;
              PWM_OUT <= 1'b0;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          PWM_OUT <= 1'b0;
        end
      endcase
    end
  end

endmodule
